// File: rtl/uart_pkg.sv
// Shared types and constants for the free-running 8N1 UART transmitter.
package uart_pkg;

  localparam int DATA_BITS        = 8;
  localparam int CLKS_PER_BIT_DEF = 434;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_GAP
  } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
  end

  // The tick is registered from the next count so it lines up with cnt_q == CNT_LAST.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == CNT_LAST);
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/uart_tx.sv
// Free-running 8N1 transmitter: resends tx_data every frame with an optional mark gap.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int GAP_BITS     = 1
) (
  input  logic                 tx_clk,
  input  logic                 nRST,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_output,
  output logic                 clk_count,
  output logic                 tx_busy
);

  localparam int GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_BITS > 0) ? GAP_W'(GAP_BITS - 1) : '0;
  localparam logic [2:0] IDX_LAST = 3'(DATA_BITS - 1);

  uart_state_e          state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [2:0]           bit_idx_q;
  logic [2:0]           next_idx;
  logic [GAP_W-1:0]     gap_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 tick;
  logic                 baud_restart;

  // IDLE lasts one cycle, so restarting here aligns the counter to the start bit.
  assign baud_restart = (state_q == ST_IDLE);
  assign next_idx     = bit_idx_q + 3'd1;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i    (tx_clk),
    .rst_ni   (nRST),
    .restart_i(baud_restart),
    .tick_o   (tick)
  );

  always_ff @(posedge tx_clk or negedge nRST) begin
    if (!nRST) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      gap_q     <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          shift_q <= tx_data;
          state_q <= ST_START;
          tx_q    <= 1'b0;
          busy_q  <= 1'b1;
        end
        ST_START: begin
          if (tick) begin
            state_q   <= ST_DATA;
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_idx_q == IDX_LAST) begin
              state_q <= ST_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_idx_q <= next_idx;
              tx_q      <= shift_q[next_idx];
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            busy_q  <= 1'b0;
            tx_q    <= 1'b1;
            gap_q   <= GAP_LOAD;
            state_q <= (GAP_BITS == 0) ? ST_IDLE : ST_GAP;
          end
        end
        ST_GAP: begin
          if (tick) begin
            if (gap_q == '0) begin
              state_q <= ST_IDLE;
            end else begin
              gap_q <= gap_q - 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_output = tx_q;
  assign tx_busy   = busy_q;
  assign clk_count = tick;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench: stimulus queues expected bytes, a receiver-style monitor decodes frames and checks them.
module tb_uart_tx;

  localparam int CPB  = 4;
  localparam int GAP1 = 1;

  logic       clk;
  logic       rst0, rst1;
  logic [7:0] data0, data1;
  logic       tx0, tx1, strb0, strb1, busy0, busy1;
  logic [1:0] mon_en;

  int n_tests;
  int n_fail;
  int cyc;

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  wire [1:0] line_s = {tx1, tx0};
  wire [1:0] busy_s = {busy1, busy0};
  wire [1:0] strb_s = {strb1, strb0};

  uart_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(0)) dut_g0 (
    .tx_clk(clk), .nRST(rst0), .tx_data(data0),
    .tx_output(tx0), .clk_count(strb0), .tx_busy(busy0)
  );

  uart_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(GAP1)) dut_g1 (
    .tx_clk(clk), .nRST(rst1), .tx_data(data1),
    .tx_output(tx1), .clk_count(strb1), .tx_busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Receiver model: on a start edge, capture one full frame plus gap/idle and grade it.
  task automatic mon_run(input int d);
    logic       prev;
    logic [9:0] bits;
    logic [7:0] exp_byte;
    logic       exp_strobe;
    bit         have_exp, aborted, stable, strobe_ok, idle_ok, busy_win_ok, last_ok;
    int         gap, nsamp, st, last_start, busy_n, b, k;
    gap        = (d == 1) ? GAP1 : 0;
    nsamp      = (10 + gap) * CPB + 1;
    prev       = 1'b1;
    last_ok    = 1'b0;
    last_start = 0;
    forever begin
      @(negedge clk);
      if (!mon_en[d]) begin
        prev    = 1'b1;
        last_ok = 1'b0;
        continue;
      end
      if (line_s[d] == 1'b0 && prev == 1'b1) begin
        have_exp    = (d == 1) ? (q1.size() > 0) : (q0.size() > 0);
        st          = cyc;
        aborted     = 1'b0;
        stable      = 1'b1;
        strobe_ok   = 1'b1;
        idle_ok     = 1'b1;
        busy_win_ok = 1'b1;
        busy_n      = 0;
        bits        = '0;
        for (int i = 0; i < nsamp; i++) begin
          if (i > 0) @(negedge clk);
          if (!mon_en[d]) begin
            aborted = 1'b1;
            break;
          end
          b = i / CPB;
          k = i % CPB;
          if (i < 10 * CPB) begin
            if (k == 0) bits[b] = line_s[d];
            else if (line_s[d] !== bits[b]) stable = 1'b0;
            if (busy_s[d] === 1'b1) busy_n++;
            else busy_win_ok = 1'b0;
          end else begin
            if (line_s[d] !== 1'b1) idle_ok = 1'b0;
            if (busy_s[d] !== 1'b0) busy_win_ok = 1'b0;
          end
          exp_strobe = (i < nsamp - 1) && (k == CPB - 1);
          if (strb_s[d] !== exp_strobe) strobe_ok = 1'b0;
        end
        if (!aborted && have_exp) begin
          exp_byte = (d == 1) ? q1.pop_front() : q0.pop_front();
          $display("[TB] g%0d frame at cycle %0d: rx=0x%02h exp=0x%02h", gap, st, bits[8:1], exp_byte);
          chk("data", {24'd0, bits[8:1]}, {24'd0, exp_byte});
          chk("framing_start_stop_stable", {29'd0, stable, bits[0], bits[9]}, 32'b101);
          chk("strobe_pattern", {31'd0, strobe_ok}, 32'd1);
          chk("busy_cycles", busy_n, 10 * CPB);
          chk("busy_window", {31'd0, busy_win_ok}, 32'd1);
          chk("idle_line", {31'd0, idle_ok}, 32'd1);
          if (last_ok) chk("frame_period", st - last_start, nsamp);
        end
        last_start = st;
        last_ok    = !aborted;
      end
      prev = line_s[d];
    end
  endtask

  initial mon_run(0);
  initial mon_run(1);

  task automatic wait_q_empty(input int d, input int budget);
    int n;
    n = 0;
    while (((d == 1) ? q1.size() : q0.size()) != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (d == 1) chk("drain_g1", q1.size(), 0);
    else        chk("drain_g0", q0.size(), 0);
  endtask

  task automatic wait_busy1(input logic val);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (busy1 !== val && n < 200);
    chk("wait_busy1", {31'd0, busy1}, {31'd0, val});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad0, bad1;
    n_tests = 0;
    n_fail  = 0;
    rst0    = 1'b0;
    rst1    = 1'b0;
    data0   = 8'hFF;
    data1   = 8'h51;
    mon_en  = 2'b00;
    bad0    = 0;
    bad1    = 0;

    // 300 ns of reset with the clock running
    repeat (30) begin
      @(negedge clk);
      if ({tx0, busy0, strb0} !== 3'b100) bad0++;
      if ({tx1, busy1, strb1} !== 3'b100) bad1++;
    end
    chk("reset_hold_g0", bad0, 0);
    chk("reset_hold_g1", bad1, 0);

    // Gap=1: two frames of 0x51, then 0xA5 picked up at the third start
    q1.push_back(8'h51);
    q1.push_back(8'h51);
    q1.push_back(8'hA5);
    rst1      = 1'b1;
    mon_en[1] = 1'b1;
    repeat (66) @(posedge clk);
    #1 data1 = 8'hA5;
    wait_q_empty(1, 500);

    // Reset during DATA bit 3 of an 0xA5 frame (bit 3 = 0)
    wait_busy1(1'b0);
    wait_busy1(1'b1);
    repeat (17) @(posedge clk);
    #2;
    chk("pre_reset_line", {31'd0, tx1}, 32'd0);
    chk("pre_reset_busy", {31'd0, busy1}, 32'd1);
    #1;
    mon_en[1] = 1'b0;
    rst1      = 1'b0;
    #1;
    chk("async_reset_line", {31'd0, tx1}, 32'd1);
    chk("async_reset_busy", {31'd0, busy1}, 32'd0);
    chk("async_reset_strobe", {31'd0, strb1}, 32'd0);
    repeat (5) @(negedge clk);
    data1 = 8'hC3;
    q1.push_back(8'hC3);
    rst1      = 1'b1;
    mon_en[1] = 1'b1;
    @(posedge clk);
    #1;
    chk("restart_line", {31'd0, tx1}, 32'd0);
    chk("restart_busy", {31'd0, busy1}, 32'd1);
    wait_q_empty(1, 200);

    // Gap=0 back-to-back 0xFF frames
    @(negedge clk);
    q0.push_back(8'hFF);
    q0.push_back(8'hFF);
    q0.push_back(8'hFF);
    rst0      = 1'b1;
    mon_en[0] = 1'b1;
    wait_q_empty(0, 400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
